// File: rtl/mdr_datapath_pkg.sv
// ============================================================================
// | Module   : pkg_system_mdr                                                |
// | Brief    : Shared op encoding, width and helper for the MDR datapath.    |
// | Revision : 1.0                                                           |
// ============================================================================
`default_nettype none

package pkg_system_mdr;

   localparam int MDR_DW = 16;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_DIV  = 2'b01,
      OP_SQRT = 2'b10,
      OP_RSV  = 2'b11
   } e_op;

   typedef struct packed {
      logic [MDR_DW-1:0]        x;
      logic [MDR_DW-1:0]        y;
      e_op                      op;
      logic                     sign_q;
      logic                     sign_r;
      logic [$clog2(MDR_DW):0]  count;
      logic [2*MDR_DW-1:0]      acc;
      logic                     done;
   } st_datapath;

   // Square root retires two radicand bits per step, hence half the steps.
   function automatic int op_iters(input e_op op, input int dw);
      return (op == OP_SQRT) ? dw / 2 : dw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mdr_datapath_iter.sv
// ============================================================================
// | Module   : mdr_iter_engine                                               |
// | Brief    : Unsigned magnitude core: shift-add MUL, restoring DIV, SQRT.  |
// | Revision : 1.0                                                           |
// ============================================================================
`default_nettype none

module mdr_iter_engine
   import pkg_system_mdr::*;
#(
   parameter int DW = MDR_DW
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clean,
   input  logic              i_init,
   input  logic              i_enable,
   input  e_op               i_op,
   input  logic [DW-1:0]     i_xmag,
   input  logic [DW-1:0]     i_ymag,
   output logic              o_done,
   output logic [2*DW-1:0]   o_mag_q,
   output logic [DW-1:0]     o_mag_r
);

   localparam int c_cw = $clog2(DW) + 1;

   e_op               r_op;
   logic [c_cw-1:0]   r_cnt;
   logic              r_done;
   logic [2*DW-1:0]   r_p;
   logic [2*DW-1:0]   r_m;
   logic [DW-1:0]     r_s;
   logic [DW-1:0]     r_r;
   logic [DW-1:0]     r_q;

   logic [2*DW-1:0]   w_p;
   logic [2*DW-1:0]   w_m;
   logic [DW-1:0]     w_s;
   logic [DW-1:0]     w_r;
   logic [DW-1:0]     w_q;
   logic [DW:0]       w_t;
   logic [DW:0]       w_trial;
   logic              w_ge;
   logic              w_last;

   assign w_last = (r_cnt == c_cw'(op_iters(r_op, DW) - 1));

   // r_m is the multiplicand for MUL and the divisor for DIV; r_s is the
   // multiplier, the dividend/quotient or the radicand depending on op.
   always_comb begin
      w_p     = r_p;
      w_m     = r_m;
      w_s     = r_s;
      w_r     = r_r;
      w_q     = r_q;
      w_t     = '0;
      w_trial = '0;
      w_ge    = 1'b0;
      case (r_op)
         OP_MUL: begin
            if (r_s[0])
               w_p = r_p + r_m;
            w_m = r_m << 1;
            w_s = r_s >> 1;
         end
         OP_DIV: begin
            w_t     = {r_r, r_s[DW-1]};
            w_trial = {1'b0, r_m[DW-1:0]};
            w_ge    = (w_t >= w_trial);
            w_r     = w_ge ? DW'(w_t - w_trial) : DW'(w_t);
            w_s     = {r_s[DW-2:0], w_ge};
         end
         OP_SQRT: begin
            w_t     = {r_r[DW-2:0], r_s[DW-1:DW-2]};
            w_trial = {r_q[DW-2:0], 2'b01};
            w_ge    = (w_t >= w_trial);
            w_r     = w_ge ? DW'(w_t - w_trial) : DW'(w_t);
            w_q     = {r_q[DW-2:0], w_ge};
            w_s     = {r_s[DW-3:0], 2'b00};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op   <= OP_MUL;
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_p    <= '0;
         r_m    <= '0;
         r_s    <= '0;
         r_r    <= '0;
         r_q    <= '0;
      end else if (i_clean) begin
         r_op   <= OP_MUL;
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_p    <= '0;
         r_m    <= '0;
         r_s    <= '0;
         r_r    <= '0;
         r_q    <= '0;
      end else if (i_init) begin
         r_op   <= i_op;
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_p    <= '0;
         r_r    <= '0;
         r_q    <= '0;
         r_m    <= {{DW{1'b0}}, (i_op == OP_MUL) ? i_xmag : i_ymag};
         r_s    <= (i_op == OP_MUL) ? i_ymag : i_xmag;
      end else if (i_enable && !r_done) begin
         r_p    <= w_p;
         r_m    <= w_m;
         r_s    <= w_s;
         r_r    <= w_r;
         r_q    <= w_q;
         r_cnt  <= r_cnt + c_cw'(1);
         if (w_last)
            r_done <= 1'b1;
      end
   end

   always_comb begin
      o_mag_q = '0;
      o_mag_r = '0;
      case (r_op)
         OP_MUL:  o_mag_q = r_p;
         OP_DIV: begin
            o_mag_q = {{DW{1'b0}}, r_s};
            o_mag_r = r_r;
         end
         OP_SQRT: begin
            o_mag_q = {{DW{1'b0}}, r_q};
            o_mag_r = r_r;
         end
         default: ;
      endcase
   end

   assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/mdr_datapath.sv
// ============================================================================
// | Module   : mdr_datapath                                                  |
// | Brief    : MDR operand capture, checks, sign fix-up and result commit.   |
// | Revision : 1.0                                                           |
// ============================================================================
`default_nettype none

module mdr_datapath
   import pkg_system_mdr::*;
#(
   parameter int DW = MDR_DW
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic [DW-1:0]  i_data,
   input  logic [1:0]     i_op,
   input  logic           i_clean,
   input  logic           i_save_x,
   input  logic           i_save_y,
   input  logic           i_veri,
   input  logic           i_init,
   input  logic           i_enable,
   input  logic           i_veri2,
   input  logic           i_ready,
   output logic           o_error1,
   output logic           o_done,
   output logic           o_error2,
   output logic [DW-1:0]  o_result,
   output logic [DW-1:0]  o_remainder
);

   // Largest positive and largest negative magnitude representable in DW bits.
   localparam logic [2*DW-1:0] c_pos_max = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic [2*DW-1:0] c_neg_max = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};

   logic [DW-1:0]    r_x;
   logic [DW-1:0]    r_y;
   e_op              r_op;
   logic             r_sign_q;
   logic             r_sign_r;

   logic [DW-1:0]    w_xmag;
   logic [DW-1:0]    w_ymag;
   logic [2*DW-1:0]  w_mag_q;
   logic [DW-1:0]    w_mag_r;
   logic             w_done;
   logic             w_ovf;
   logic [DW-1:0]    w_res;
   logic [DW-1:0]    w_rem;

   // Unsigned DW bits already hold 2^(DW-1), so the most negative operand is exact.
   assign w_xmag = r_x[DW-1] ? (~r_x + DW'(1)) : r_x;
   assign w_ymag = r_y[DW-1] ? (~r_y + DW'(1)) : r_y;

   mdr_iter_engine #(.DW(DW)) u_engine (
      .clk      (clk),
      .rst      (rst),
      .i_clean  (i_clean),
      .i_init   (i_init),
      .i_enable (i_enable),
      .i_op     (r_op),
      .i_xmag   (w_xmag),
      .i_ymag   (w_ymag),
      .o_done   (w_done),
      .o_mag_q  (w_mag_q),
      .o_mag_r  (w_mag_r)
   );

   assign w_ovf = (r_sign_q && (|w_mag_q)) ? (w_mag_q > c_neg_max)
                                           : (w_mag_q > c_pos_max);
   assign w_res = r_sign_q ? (~w_mag_q[DW-1:0] + DW'(1)) : w_mag_q[DW-1:0];
   assign w_rem = r_sign_r ? (~w_mag_r + DW'(1)) : w_mag_r;

   assign o_error1 = i_veri & ((r_op == OP_RSV)
                             | ((r_op == OP_DIV) & (r_y == '0))
                             | ((r_op == OP_SQRT) & r_x[DW-1]));
   assign o_error2 = i_veri2 & w_done & w_ovf;
   assign o_done   = w_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x         <= '0;
         r_y         <= '0;
         r_op        <= OP_MUL;
         r_sign_q    <= 1'b0;
         r_sign_r    <= 1'b0;
         o_result    <= '0;
         o_remainder <= '0;
      end else if (i_clean) begin
         r_x         <= '0;
         r_y         <= '0;
         r_op        <= OP_MUL;
         r_sign_q    <= 1'b0;
         r_sign_r    <= 1'b0;
         o_result    <= '0;
         o_remainder <= '0;
      end else begin
         if (i_save_x)
            r_x <= i_data;
         if (i_save_y) begin
            r_y  <= i_data;
            r_op <= e_op'(i_op);
         end
         if (i_init) begin
            r_sign_q <= (r_op != OP_SQRT) & (r_x[DW-1] ^ r_y[DW-1]);
            r_sign_r <= r_x[DW-1];
         end
         if (i_ready && w_done) begin
            o_result    <= w_res;
            o_remainder <= w_rem;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mdr_datapath.sv
// ============================================================================
// | Module   : tb_mdr_datapath                                               |
// | Brief    : Scoreboard bench for mdr_datapath against an arithmetic model.|
// | Revision : 1.0                                                           |
// ============================================================================
`default_nettype none

module tb_mdr_datapath;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] i_data = '0;
   logic [1:0]  i_op = '0;
   logic        i_clean = 0, i_save_x = 0, i_save_y = 0, i_veri = 0;
   logic        i_init = 0, i_enable = 0, i_veri2 = 0, i_ready = 0;
   logic        o_error1, o_done, o_error2;
   logic [15:0] o_result, o_remainder;

   always #5 clk = ~clk;

   mdr_datapath #(.DW(16)) dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_op(i_op), .i_clean(i_clean),
      .i_save_x(i_save_x), .i_save_y(i_save_y), .i_veri(i_veri), .i_init(i_init),
      .i_enable(i_enable), .i_veri2(i_veri2), .i_ready(i_ready),
      .o_error1(o_error1), .o_done(o_done), .o_error2(o_error2),
      .o_result(o_result), .o_remainder(o_remainder)
   );

   typedef struct { logic [15:0] res; logic [15:0] rem; } res_t;

   int   n_chk = 0;
   int   n_pass = 0;
   bit   q_e1[$];
   bit   q_e2[$];
   res_t q_res[$];
   int   q_lat[$];
   logic probe = 1'b0;
   logic [15:0] prev_res = '0, prev_rem = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference: plain signed arithmetic on the two's-complement operands.
   task automatic model(input int op, input logic [15:0] x, input logic [15:0] y,
                        output bit e1, output bit e2,
                        output logic [15:0] res, output logic [15:0] rem);
      longint sx, sy, p, r, root;
      sx = $signed(x);
      sy = $signed(y);
      p = 0; r = 0;
      case (op)
         0: p = sx * sy;
         1: if (sy != 0) begin p = sx / sy; r = sx % sy; end
         2: begin
            root = 0;
            while ((root + 1) * (root + 1) <= sx) root++;
            p = root;
            r = sx - root * root;
         end
         default: ;
      endcase
      e1  = (op == 3) || (op == 1 && sy == 0) || (op == 2 && sx < 0);
      e2  = (p > 32767) || (p < -32768);
      res = p[15:0];
      rem = r[15:0];
   endtask

   // Monitor: pops expectations whenever the DUT presents a response.
   logic done_q = 1'b0;
   logic pend = 1'b0;
   int   en_cnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         if (i_veri) begin
            if (q_e1.size() == 0) chk("error1 unexpected", 1, 0);
            else chk("error1", o_error1, q_e1.pop_front());
         end
         if (i_veri2) begin
            if (q_e2.size() == 0) chk("error2 unexpected", 1, 0);
            else chk("error2", o_error2, q_e2.pop_front());
         end
         if (pend) begin
            pend = 1'b0;
            if (q_res.size() == 0) chk("result unexpected", 1, 0);
            else begin
               res_t e;
               e = q_res.pop_front();
               chk("result", o_result, e.res);
               chk("remainder", o_remainder, e.rem);
            end
         end
         if ((i_ready && o_done) || probe) pend = 1'b1;
         if (o_done && !done_q) begin
            if (q_lat.size() == 0) chk("done unexpected", 1, 0);
            else chk("done latency", en_cnt, q_lat.pop_front());
         end
         if (i_init) en_cnt = 0;
         else if (i_enable && !o_done) en_cnt++;
         done_q = o_done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_clean = 0; i_save_x = 0; i_save_y = 0; i_veri = 0;
      i_init = 0; i_enable = 0; i_veri2 = 0; i_ready = 0;
   endtask

   task automatic load(input int op, input logic [15:0] x, input logic [15:0] y);
      i_data = x; i_save_x = 1; tick(); idle();
      i_data = y; i_op = op[1:0]; i_save_y = 1; tick(); idle();
   endtask

   task automatic partial(input int op, input logic [15:0] x, input logic [15:0] y, input int k);
      load(op, x, y);
      i_init = 1; tick(); idle();
      repeat (k) begin i_enable = 1; tick(); idle(); end
   endtask

   task automatic run_op(input int op, input logic [15:0] x, input logic [15:0] y,
                         input int gap_at, input int extra);
      bit e1, e2;
      logic [15:0] r, m;
      int n;
      model(op, x, y, e1, e2, r, m);
      n = (op == 2) ? 8 : 16;
      load(op, x, y);
      q_e1.push_back(e1);
      i_veri = 1; tick(); idle();
      if (e1) return;
      q_lat.push_back(n);
      i_init = 1; tick(); idle();
      for (int k = 0; k < n; k++) begin
         if (k == gap_at) repeat (3) tick();
         i_enable = 1; tick(); idle();
      end
      repeat (extra) begin i_enable = 1; tick(); idle(); end
      q_e2.push_back(e2);
      i_veri2 = 1; tick(); idle();
      if (!e2) begin
         prev_res = r; prev_rem = m;
         i_ready = 1;
      end else probe = 1'b1;
      q_res.push_back('{prev_res, prev_rem});
      tick(); idle(); probe = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2 rst = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset done", o_done, 0);
      chk("reset result", o_result, 0);
      chk("reset remainder", o_remainder, 0);
      rst = 1;
      tick();

      run_op(0, 16'd300, -16'sd7, -1, 0);
      run_op(1, -16'sd100, 16'd7, -1, 0);
      run_op(1, 16'd5, 16'd0, -1, 0);
      run_op(2, 16'd1000, 16'd0, -1, 0);
      run_op(2, -16'sd4, 16'd0, -1, 0);
      run_op(3, 16'd9, 16'd9, -1, 0);
      run_op(0, 16'd300, 16'd200, -1, 0);
      run_op(1, 16'h8000, 16'hFFFF, -1, 0);
      run_op(0, 16'h8000, 16'd1, -1, 0);
      run_op(0, 16'd123, -16'sd45, 5, 0);
      run_op(1, 16'd1000, -16'sd33, -1, 2);
      run_op(0, 16'd0, -16'sd9, -1, 0);

      partial(0, 16'd300, 16'd7, 7);
      run_op(2, 16'd30000, 16'd0, -1, 0);

      partial(0, 16'd1234, 16'd5, 5);
      i_clean = 1; tick(); idle();
      chk("clean done", o_done, 0);
      chk("clean result", o_result, 0);
      chk("clean remainder", o_remainder, 0);
      prev_res = '0; prev_rem = '0;

      run_op(1, 16'd77, 16'd3, -1, 0);
      partial(1, -16'sd1000, 16'd3, 6);
      #2 rst = 0;
      #1;
      chk("async rst done", o_done, 0);
      chk("async rst result", o_result, 0);
      chk("async rst remainder", o_remainder, 0);
      @(posedge clk); #1 rst = 1;
      prev_res = '0; prev_rem = '0;
      tick();

      for (int i = 0; i < 20; i++) begin
         int op;
         logic [15:0] x, y;
         op = $urandom_range(0, 9) == 0 ? 3 : int'($urandom_range(0, 2));
         x  = 16'($urandom_range(0, 65535));
         y  = 16'($urandom_range(0, 65535));
         if (op == 0 && $urandom_range(0, 1) == 1) begin
            x = 16'(int'($urandom_range(0, 600)) - 300);
            y = 16'(int'($urandom_range(0, 200)) - 100);
         end
         if (op == 2 && $urandom_range(0, 3) != 0) x = 16'($urandom_range(0, 32767));
         run_op(op, x, y, int'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
      end

      chk("queues drained", q_e1.size() + q_e2.size() + q_res.size() + q_lat.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
